// File: rtl/gpio_vector_pkg.sv
// Shared types and helpers for the GPIO vector monitor.
package gpio_vector_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StTrack,
    StPass,
    StFail
  } state_e;

  localparam int unsigned ERRCNT_W = 16;

  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/gpio_vector_sync.sv
// WIDTH x STAGES flop synchroniser for an asynchronous input vector.
module gpio_vector_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_vector_monitor.sv
// On-chip checker for a counting pattern on a GPIO slice; sticky pass/fail/timeout status.
// Optional mismatch counting/resync build: define GPIO_VECTOR_MONITOR_ERRCNT_EN.
module gpio_vector_monitor
  import gpio_vector_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned START       = 0,
  parameter int unsigned END         = 33,
  parameter int unsigned STEP        = 1,
  parameter int unsigned TIMEOUT     = 24000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [WIDTH-1:0]    vec_in,
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [WIDTH-1:0]    last_value,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int unsigned TimerW = timer_width(TIMEOUT);
  localparam logic [WIDTH-1:0] StartV = WIDTH'(START);
  localparam logic [WIDTH-1:0] EndV = WIDTH'(END);
  localparam logic [WIDTH-1:0] StepV = WIDTH'(STEP);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT);

  state_e              state_q;
  logic                busy_q, pass_q, fail_q, timeout_q;
  logic [WIDTH-1:0]    last_q;
  logic [TimerW-1:0]   timer_q;
  logic [WIDTH-1:0]    sample;
  logic [WIDTH-1:0]    expected;
  logic [TimerW-1:0]   timer_inc;
`ifdef GPIO_VECTOR_MONITOR_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_q;
`endif

  gpio_vector_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (vec_in),
    .q_o   (sample)
  );

  assign expected  = last_q + StepV;
  assign timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= '0;
      timer_q   <= '0;
`ifdef GPIO_VECTOR_MONITOR_ERRCNT_EN
      err_q     <= '0;
`endif
    end else if (!enable) begin
      // Silent abort: flags clear, last value and error count are kept.
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StWaitStart;
          busy_q  <= 1'b1;
          timer_q <= '0;
`ifdef GPIO_VECTOR_MONITOR_ERRCNT_EN
          err_q   <= '0;
`endif
        end
        StWaitStart: begin
          if (sample == StartV) begin
            last_q  <= StartV;
            timer_q <= '0;
            if (StartV == EndV) begin
              state_q <= StPass;
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
            end else begin
              state_q <= StTrack;
            end
          end else if (timer_q >= TimerLast) begin
            state_q   <= StFail;
            busy_q    <= 1'b0;
            fail_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StTrack: begin
          // Accept is tested first so it wins over a same-cycle timeout.
          if (sample == expected) begin
            last_q  <= sample;
            timer_q <= '0;
            if (sample == EndV) begin
              state_q <= StPass;
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
            end
          end else if (sample == last_q) begin
            if (timer_q >= TimerLast) begin
              state_q   <= StFail;
              busy_q    <= 1'b0;
              fail_q    <= 1'b1;
              timeout_q <= 1'b1;
            end else begin
              timer_q <= timer_inc;
            end
          end else begin
`ifdef GPIO_VECTOR_MONITOR_ERRCNT_EN
            if (err_q != '1) begin
              err_q <= err_q + 1'b1;
            end
            last_q  <= sample;
            timer_q <= '0;
`else
            state_q   <= StFail;
            busy_q    <= 1'b0;
            fail_q    <= 1'b1;
            timeout_q <= 1'b0;
`endif
          end
        end
        StPass, StFail: begin
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign last_value = last_q;
`ifdef GPIO_VECTOR_MONITOR_ERRCNT_EN
  assign err_count  = err_q;
`else
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_gpio_vector_monitor.sv
// Directed bench for gpio_vector_monitor: stimulus table plus multi-cycle scenarios.
module tb_gpio_vector_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        en_w = 1'b0;
  logic [7:0]  vec = '0;
  logic [3:0]  vec_w = '0;
  logic        busy, pass, fail, tmo;
  logic [7:0]  last;
  logic [15:0] err;
  logic        busy_w, pass_w, fail_w, tmo_w;
  logic [3:0]  last_w;
  logic [15:0] err_w;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  gpio_vector_monitor #(
    .WIDTH(8), .START(0), .END(33), .STEP(1), .TIMEOUT(100), .SYNC_STAGES(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (en),
    .vec_in     (vec),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .timeout    (tmo),
    .last_value (last),
    .err_count  (err)
  );

  gpio_vector_monitor #(
    .WIDTH(4), .START(14), .END(2), .STEP(1), .TIMEOUT(100), .SYNC_STAGES(2)
  ) dut_w (
    .clock      (clock),
    .reset      (reset),
    .enable     (en_w),
    .vec_in     (vec_w),
    .busy       (busy_w),
    .pass       (pass_w),
    .fail       (fail_w),
    .timeout    (tmo_w),
    .last_value (last_w),
    .err_count  (err_w)
  );

  typedef struct {
    logic       en;
    logic [7:0] vec;
    int         cyc;
    logic       busy;
    logic       pass;
    logic       fail;
    logic       tmo;
    logic       chk_last;
    logic [7:0] last;
  } row_t;

  row_t tbl[9];

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_seq(input int lo, input int hi, input int hold);
    for (int v = lo; v <= hi; v++) begin
      vec = 8'(v);
      step(hold);
    end
  endtask

  // Return to IDLE, then re-enable with START already sampled.
  task automatic arm();
    en  = 1'b0;
    vec = 8'd0;
    step(4);
    en = 1'b1;
    step(3);
  endtask

  initial begin
    int lat;
    int w;

    //            en    vec    cyc  busy  pass  fail  tmo   chkL  last
    tbl[0] = '{1'b0, 8'd0, 4,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[1] = '{1'b1, 8'd0, 5,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[2] = '{1'b1, 8'd1, 6,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[3] = '{1'b1, 8'd2, 6,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[4] = '{1'b1, 8'd3, 150, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3};
    tbl[5] = '{1'b1, 8'd5, 6,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3};
    tbl[6] = '{1'b0, 8'd5, 3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[7] = '{1'b1, 8'd5, 110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[8] = '{1'b0, 8'd0, 3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    @(negedge clock);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_flags", 32'({pass, fail, tmo}), 0);
    chk("reset_last", 32'(last), 0);
    chk("reset_err", 32'(err), 0);
    step(1);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      en  = tbl[i].en;
      vec = tbl[i].vec;
      step(tbl[i].cyc);
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d_pass", i), 32'(pass), 32'(tbl[i].pass));
      chk($sformatf("row%0d_fail", i), 32'(fail), 32'(tbl[i].fail));
      chk($sformatf("row%0d_timeout", i), 32'(tmo), 32'(tbl[i].tmo));
      chk($sformatf("row%0d_err", i), 32'(err), 0);
      if (tbl[i].chk_last) chk($sformatf("row%0d_last", i), 32'(last), 32'(tbl[i].last));
    end

    // Full count: pass must follow 33 within SYNC_STAGES+2 cycles.
    arm();
    drive_seq(1, 32, 50);
    chk("count_pass_early", 32'(pass), 0);
    vec = 8'd33;
    lat = 0;
    while (!pass && lat < 4) begin
      step(1);
      lat++;
    end
    chk("count_pass", 32'(pass), 1);
    chk("count_fail", 32'(fail), 0);
    chk("count_last", 32'(last), 33);

    // Skip from 5 to 7.
    arm();
    drive_seq(1, 5, 10);
    vec = 8'd7;
    step(10);
    chk("skip_pass", 32'(pass), 0);
`ifdef GPIO_VECTOR_MONITOR_ERRCNT_EN
    chk("skip_fail", 32'(fail), 0);
    chk("skip_busy", 32'(busy), 1);
    chk("skip_last", 32'(last), 7);
    chk("skip_err", 32'(err), 1);
`else
    chk("skip_fail", 32'(fail), 1);
    chk("skip_timeout", 32'(tmo), 0);
    chk("skip_last", 32'(last), 5);
`endif

    // Stall on 3: timeout lands about 100 cycles after the accept.
    arm();
    drive_seq(1, 2, 10);
    vec = 8'd3;
    step(90);
    chk("stall_no_fail_yet", 32'(fail), 0);
    chk("stall_last", 32'(last), 3);
    w = 0;
    while (!fail && w < 20) begin
      step(1);
      w++;
    end
    chk("stall_fail", 32'(fail), 1);
    chk("stall_timeout", 32'(tmo), 1);

    // Abort at 10 then rerun to pass.
    arm();
    drive_seq(1, 10, 10);
    chk("abort_busy_run", 32'(busy), 1);
    chk("abort_last_run", 32'(last), 10);
    en = 1'b0;
    step(1);
    chk("abort_idle_busy", 32'(busy), 0);
    chk("abort_idle_flags", 32'({pass, fail, tmo}), 0);
    vec = 8'd0;
    step(3);
    en = 1'b1;
    step(3);
    drive_seq(1, 33, 10);
    chk("abort_rerun_pass", 32'(pass), 1);
    chk("abort_rerun_last", 32'(last), 33);

    // Asynchronous reset mid-run.
    arm();
    drive_seq(1, 10, 10);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({pass, fail, tmo}), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_err", 32'(err), 0);
    step(1);
    reset = 1'b0;

    // Mismatch at 9 then continue counting.
    arm();
    drive_seq(1, 5, 10);
    vec = 8'd9;
    step(10);
    drive_seq(10, 33, 10);
`ifdef GPIO_VECTOR_MONITOR_ERRCNT_EN
    chk("errcnt_pass", 32'(pass), 1);
    chk("errcnt_fail", 32'(fail), 0);
    chk("errcnt_err", 32'(err), 1);
    chk("errcnt_last", 32'(last), 33);
`else
    chk("errcnt_pass", 32'(pass), 0);
    chk("errcnt_fail", 32'(fail), 1);
    chk("errcnt_timeout", 32'(tmo), 0);
    chk("errcnt_err", 32'(err), 0);
`endif

    // 4-bit wrap: 14,15,0,1,2.
    vec_w = 4'd14;
    step(4);
    en_w = 1'b1;
    step(3);
    chk("wrap_busy", 32'(busy_w), 1);
    vec_w = 4'd15;
    step(10);
    vec_w = 4'd0;
    step(10);
    vec_w = 4'd1;
    step(10);
    chk("wrap_pass_early", 32'(pass_w), 0);
    chk("wrap_last_mid", 32'(last_w), 1);
    vec_w = 4'd2;
    step(10);
    chk("wrap_pass", 32'(pass_w), 1);
    chk("wrap_fail", 32'(fail_w), 0);
    chk("wrap_last", 32'(last_w), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
